pc_unit_v2: RTL and testbench

- Parametrised fetch-stage program counter for the pipelined core; successor to the current fixed 32-bit PC.
- Selects next PC from sequential, ID jump, EX branch/jump-register, exception and interrupt sources, with a fixed priority.
- Adds an interrupt-pending latch, EPC capture, and a redirect-hold register so a redirect arriving during a fetch stall is not lost.
- Sits between the IF stage and the ID/EX redirect logic.

---
 rtl/pc_unit_v2.sv | 117 +++++++++++
 tb/tb_pc_unit_v2.sv | 117 +++++++++++
 2 files changed

// File: rtl/pc_unit_v2.sv
// pc_unit_v2: fetch-stage program counter with prioritised redirects, IRQ latch, EPC capture and redirect hold
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   if_upd_pc           1 = fetch may advance, 0 = fetch stall
//   id_jump/id_jt       ID unconditional jump and its target
//   ex_branch/ex_conba  EX taken branch and its target
//   ex_jr/ex_jr_target  EX jump-register and its target
//   exc/exc_pc          exception pulse and faulting PC
//   irq                 level interrupt request
//   if_pc               current fetch PC
//   kernel              supervisor bit (if_pc MSB when KEEP_MSB=1)
//   epc                 return address captured on exception/interrupt entry
//   irq_ack             one-cycle pulse on interrupt entry
//   redirect_pending    a redirect is parked waiting for the stall to clear
module pc_unit_v2 #(
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_VEC = 32'h80000000,
    parameter logic [PC_W-1:0] EXC_VEC   = 32'h80000004,
    parameter logic [PC_W-1:0] IRQ_VEC   = 32'h80000008,
    parameter int              STEP      = 4,
    parameter bit              KEEP_MSB  = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_upd_pc,
    input  logic            id_jump,
    input  logic [PC_W-1:0] id_jt,
    input  logic            ex_branch,
    input  logic [PC_W-1:0] ex_conba,
    input  logic            ex_jr,
    input  logic [PC_W-1:0] ex_jr_target,
    input  logic            exc,
    input  logic [PC_W-1:0] exc_pc,
    input  logic            irq,
    output logic [PC_W-1:0] if_pc,
    output logic            kernel,
    output logic [PC_W-1:0] epc,
    output logic            irq_ack,
    output logic            redirect_pending
);
    localparam int MSB = PC_W - 1;
    localparam logic [PC_W-1:0] STEP_W = PC_W'(STEP);

    typedef enum logic {RUN, HOLD} state_t;

    state_t          r_state, w_state_nx;
    logic [PC_W-1:0] r_pc, r_epc, r_hold_tgt;
    logic [PC_W-1:0] w_pc_nx, w_epc_nx, w_hold_tgt_nx, w_seq, w_tgt;
    logic            r_irq_pend, r_irq_ack;
    logic            w_redir, w_pend, w_irq_take, w_kernel;

    // With KEEP_MSB the supervisor bit is never carried into
    assign w_seq    = KEEP_MSB ? {r_pc[MSB], r_pc[MSB-1:0] + STEP_W[MSB-1:0]} : r_pc + STEP_W;
    assign w_kernel = KEEP_MSB ? r_pc[MSB] : 1'b0;
    assign w_redir  = ex_jr | ex_branch | id_jump;
    // EX is older than ID, so it wins; jr beats branch
    assign w_tgt    = ex_jr ? ex_jr_target : ex_branch ? ex_conba : id_jt;
    // A request seen this cycle is eligible immediately, not only once latched
    assign w_pend   = r_irq_pend | irq;

    always_comb begin
        w_state_nx    = r_state;
        w_pc_nx       = r_pc;
        w_epc_nx      = r_epc;
        w_hold_tgt_nx = r_hold_tgt;
        w_irq_take    = 1'b0;
        if (exc) begin
            w_pc_nx    = EXC_VEC;
            w_epc_nx   = exc_pc;
            w_state_nx = RUN;
        end else if (r_state == HOLD) begin
            if (if_upd_pc) begin
                w_pc_nx    = w_redir ? w_tgt : r_hold_tgt;
                w_state_nx = RUN;
            end else if (w_redir) begin
                w_hold_tgt_nx = w_tgt;
            end
        end else if (if_upd_pc) begin
            if (w_redir) begin
                w_pc_nx = w_tgt;
            end else if (w_pend && !w_kernel) begin
                w_pc_nx    = IRQ_VEC;
                w_epc_nx   = w_seq;
                w_irq_take = 1'b1;
            end else begin
                w_pc_nx = w_seq;
            end
        end else if (w_redir) begin
            w_hold_tgt_nx = w_tgt;
            w_state_nx    = HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= RUN;
            r_pc       <= RESET_VEC;
            r_epc      <= '0;
            r_hold_tgt <= '0;
            r_irq_pend <= 1'b0;
            r_irq_ack  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_pc       <= w_pc_nx;
            r_epc      <= w_epc_nx;
            r_hold_tgt <= w_hold_tgt_nx;
            r_irq_pend <= w_irq_take ? 1'b0 : w_pend;
            r_irq_ack  <= w_irq_take;
        end
    end

    assign if_pc            = r_pc;
    assign kernel           = w_kernel;
    assign epc              = r_epc;
    assign irq_ack          = r_irq_ack;
    assign redirect_pending = (r_state == HOLD);
endmodule

// File: tb/tb_pc_unit_v2.sv
// tb_pc_unit_v2: directed self-checking bench for pc_unit_v2 (KEEP_MSB=1 and KEEP_MSB=0 instances)
module tb_pc_unit_v2;
    logic        clk = 1'b0;
    logic        reset, if_upd_pc, id_jump, ex_branch, ex_jr, exc, irq;
    logic [31:0] id_jt, ex_conba, ex_jr_target, exc_pc;
    logic [31:0] pc0, epc0, pc1, epc1;
    logic        k0, ack0, rp0, k1, ack1, rp1;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    pc_unit_v2 u0 (
        .clk(clk), .reset(reset), .if_upd_pc(if_upd_pc),
        .id_jump(id_jump), .id_jt(id_jt), .ex_branch(ex_branch), .ex_conba(ex_conba),
        .ex_jr(ex_jr), .ex_jr_target(ex_jr_target), .exc(exc), .exc_pc(exc_pc), .irq(irq),
        .if_pc(pc0), .kernel(k0), .epc(epc0), .irq_ack(ack0), .redirect_pending(rp0)
    );

    pc_unit_v2 #(.KEEP_MSB(1'b0)) u1 (
        .clk(clk), .reset(reset), .if_upd_pc(if_upd_pc),
        .id_jump(id_jump), .id_jt(id_jt), .ex_branch(ex_branch), .ex_conba(ex_conba),
        .ex_jr(ex_jr), .ex_jr_target(ex_jr_target), .exc(exc), .exc_pc(exc_pc), .irq(irq),
        .if_pc(pc1), .kernel(k1), .epc(epc1), .irq_ack(ack1), .redirect_pending(rp1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; if_upd_pc = 1'b0; id_jump = 1'b0; ex_branch = 1'b0; ex_jr = 1'b0;
        exc = 1'b0; irq = 1'b0; id_jt = '0; ex_conba = '0; ex_jr_target = '0; exc_pc = '0;
        step(); step();
        reset = 1'b0;
        check("rst_pc", pc0, 32'h80000000);
        check("rst_epc", epc0, 32'h0);
        check("rst_ack", {31'b0, ack0}, 32'h0);
        check("rst_pend", {31'b0, rp0}, 32'h0);
        check("rst_kernel", {31'b0, k0}, 32'h1);
        check("rst_k1", {31'b0, k1}, 32'h0);

        if_upd_pc = 1'b1;
        step(); check("seq1", pc0, 32'h80000004);
        step(); check("seq2", pc0, 32'h80000008);
        step(); check("seq3", pc0, 32'h8000000C);
        check("seq_kernel", {31'b0, k0}, 32'h1);

        ex_jr = 1'b1; ex_jr_target = 32'hFFFFFFFC;
        step(); check("jr_full0", pc0, 32'hFFFFFFFC);
        check("jr_full1", pc1, 32'hFFFFFFFC);
        ex_jr = 1'b0;
        step(); check("wrap_keep", pc0, 32'h80000000);
        check("wrap_nokeep", pc1, 32'h00000000);

        id_jump = 1'b1; id_jt = 32'h100; ex_branch = 1'b1; ex_conba = 32'h200;
        step(); check("br_over_id", pc0, 32'h00000200);
        ex_jr = 1'b1; ex_jr_target = 32'h500;
        step(); check("jr_over_br", pc0, 32'h00000500);
        id_jump = 1'b0; ex_branch = 1'b0;

        if_upd_pc = 1'b0; ex_jr_target = 32'h300;
        step(); check("stall_hold_pc", pc0, 32'h00000500);
        check("stall_pending", {31'b0, rp0}, 32'h1);
        ex_jr = 1'b0;
        step(); step();
        check("stall2_pc", pc0, 32'h00000500);
        id_jump = 1'b1; id_jt = 32'h400;
        step(); check("overwrite_pend", {31'b0, rp0}, 32'h1);
        id_jump = 1'b0; if_upd_pc = 1'b1;
        step(); check("release_pc", pc0, 32'h00000400);
        check("release_pend", {31'b0, rp0}, 32'h0);
        step(); check("post_release", pc0, 32'h00000404);

        ex_jr = 1'b1; ex_jr_target = 32'h80000100;
        step(); check("to_kernel", pc0, 32'h80000100);
        ex_jr = 1'b0; irq = 1'b1;
        step(); check("irq_kernel_pc", pc0, 32'h80000104);
        check("irq_kernel_ack", {31'b0, ack0}, 32'h0);
        irq = 1'b0;
        step(); check("irq_wait_pc", pc0, 32'h80000108);
        id_jump = 1'b1; id_jt = 32'h1000;
        step(); check("to_user", pc0, 32'h00001000);
        check("to_user_ack", {31'b0, ack0}, 32'h0);
        id_jump = 1'b0;
        step(); check("irq_entry_pc", pc0, 32'h80000008);
        check("irq_entry_epc", epc0, 32'h00001004);
        check("irq_entry_ack", {31'b0, ack0}, 32'h1);
        step(); check("irq_ack_drop", {31'b0, ack0}, 32'h0);
        check("irq_after_pc", pc0, 32'h8000000C);

        if_upd_pc = 1'b0; ex_branch = 1'b1; ex_conba = 32'h600;
        step(); check("hold2_pc", pc0, 32'h8000000C);
        check("hold2_pend", {31'b0, rp0}, 32'h1);
        ex_branch = 1'b0; exc = 1'b1; exc_pc = 32'h2000;
        step(); check("exc_pc", pc0, 32'h80000004);
        check("exc_epc", epc0, 32'h00002000);
        check("exc_pend", {31'b0, rp0}, 32'h0);
        exc = 1'b1; exc_pc = 32'h3000; reset = 1'b1;
        step(); check("rst2_pc", pc0, 32'h80000000);
        check("rst2_epc", epc0, 32'h0);
        check("rst2_pend", {31'b0, rp0}, 32'h0);
        reset = 1'b0; exc = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
